// File: rtl/mul_div_unit.sv
// mul_div_unit: iterative multiply/divide unit with architectural HI/LO registers.
//
// Runs MULT/MULTU (radix-2 shift-add) and DIV/DIVU (restoring) over WIDTH
// iterations, then writes HI/LO in a single FINISH cycle. Signed operations
// work on magnitudes, and the result signs are applied at FINISH.
// Result latency is WIDTH+1 cycles from the accept edge.
//
// Configuration macro: MULDIV_DIV_EN
//   defined   -> DIV/DIVU are implemented.
//   undefined -> the divider datapath is removed, and a start with op 1x is ignored.
//
// Ports:
//   clk, rst_n         clock, synchronous active-low reset
//   start, op          request and opcode (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   opA, opB           multiplicand/dividend, multiplier/divisor
//   flush              cancels in-flight work; HI/LO are left untouched
//   hi_we, lo_we       MTHI/MTLO write enables (honoured only while idle)
//   wdata              MTHI/MTLO data
//   busy               operation in flight (CALC or FINISH)
//   done               one-cycle pulse after HI/LO receive a result
//   hi, lo             architectural HI/LO registers
module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic             flush,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FINISH} state_t;

  state_t             state, state_nxt;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc;       // {upper, lower} working register
  logic [WIDTH-1:0]   opnd;      // multiplicand magnitude or divisor magnitude
  logic               a_neg, b_neg;
`ifdef MULDIV_DIV_EN
  logic               is_div;
`endif

  logic               op_ok, accept, op_signed, res_neg;
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] step, prod;
  logic [WIDTH-1:0]   fin_hi, fin_lo;

`ifdef MULDIV_DIV_EN
  assign op_ok = 1'b1;
`else
  assign op_ok = ~op[1];
`endif

  // flush wins over start in IDLE
  assign accept    = (state == IDLE) && start && !flush && op_ok;
  assign op_signed = ~op[0];
  assign a_mag     = (op_signed && opA[WIDTH-1]) ? -opA : opA;
  assign b_mag     = (op_signed && opB[WIDTH-1]) ? -opB : opB;
  assign res_neg   = a_neg ^ b_neg;

  // ---------------- FSM: state register ----------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // ---------------- FSM: next-state logic ----------------
  // NOTE: the default assignment at the top keeps this block free of
  // inferred latches on paths that don't assign state_nxt.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = CALC;
      CALC:    if (flush) state_nxt = IDLE;
               else if (cnt == CW'(WIDTH - 1)) state_nxt = FINISH;
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    busy = (state != IDLE);
  end

  // ---------------- iteration step ----------------
  // Multiply: add the multiplicand into the upper half when the multiplier
  // LSB is set, then shift right. The carry goes into the top bit.
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0] div_shift, div_diff;
  // Restoring divide: shift the next dividend bit into the remainder and
  // try subtracting the divisor. A borrow (bit WIDTH set) means restore.
  assign div_shift = acc[2*WIDTH-1:WIDTH-1];
  assign div_diff  = div_shift - {1'b0, opnd};

  always_comb begin
    step = {mul_sum, acc[WIDTH-1:1]};
    if (is_div) begin
      if (div_diff[WIDTH]) step = {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
      else                 step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    end
  end
`else
  assign step = {mul_sum, acc[WIDTH-1:1]};
`endif

  // ---------------- result formatting at FINISH ----------------
  assign prod = res_neg ? -acc : acc;

`ifdef MULDIV_DIV_EN
  logic [WIDTH-1:0] quot, rem;
  assign quot = acc[WIDTH-1:0];
  assign rem  = acc[2*WIDTH-1:WIDTH];
`endif

  always_comb begin
    fin_hi = prod[2*WIDTH-1:WIDTH];
    fin_lo = prod[WIDTH-1:0];
`ifdef MULDIV_DIV_EN
    if (is_div) begin
      // MIN / -1 gives |MIN| as the quotient magnitude. Negating it gives MIN
      // back with remainder 0, so no special case is needed. With a zero
      // divisor the remainder magnitude is |opA|, so re-signing it restores opA.
      fin_lo = (opnd == '0) ? '1 : (res_neg ? -quot : quot);
      fin_hi = a_neg ? -rem : rem;
    end
`endif
  end

  // ---------------- datapath and HI/LO ----------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt   <= '0;
      acc   <= '0;
      opnd  <= '0;
      a_neg <= 1'b0;
      b_neg <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div <= 1'b0;
`endif
      done  <= 1'b0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
      if (accept) begin
        cnt   <= '0;
        a_neg <= op_signed & opA[WIDTH-1];
        b_neg <= op_signed & opB[WIDTH-1];
`ifdef MULDIV_DIV_EN
        is_div <= op[1];
        if (op[1]) begin
          acc  <= {{WIDTH{1'b0}}, a_mag};
          opnd <= b_mag;
        end else
`endif
        begin
          acc  <= {{WIDTH{1'b0}}, b_mag};
          opnd <= a_mag;
        end
      end else if (state == CALC && !flush) begin
        acc <= step;
        cnt <= cnt + 1'b1;
      end
      if (state == FINISH && !flush) begin
        hi   <= fin_hi;
        lo   <= fin_lo;
        done <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit: self-checking bench for mul_div_unit (WIDTH=32).
// Directed cases plus randomized operations are checked against a plain-
// arithmetic reference model. Follows MULDIV_DIV_EN the same way the DUT does.
module tb_mul_div_unit;

  localparam int W = 32;
`ifdef MULDIV_DIV_EN
  localparam bit DIV_EN = 1'b1;
`else
  localparam bit DIV_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n, start, flush, hi_we, lo_we;
  logic [1:0]   op;
  logic [W-1:0] opA, opB, wdata, hi, lo;
  logic         busy, done;

  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] exp_hi, exp_lo;

  mul_div_unit #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .opA(opA), .opB(opB),
    .flush(flush), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h", tag, got, expv);
    end
  endtask

  // Advance one cycle and settle just after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: HI/LO for one operation, from the arithmetic definition.
  function automatic void model(input logic [1:0] o, input logic [W-1:0] a, b,
                                output logic [W-1:0] eh, output logic [W-1:0] el);
    logic [63:0] p;
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    eh = '0;
    el = '0;
    case (o)
      2'b00: begin p = 64'(sa * sb); eh = p[63:32]; el = p[31:0]; end
      2'b01: begin p = {32'b0, a} * {32'b0, b}; eh = p[63:32]; el = p[31:0]; end
      2'b10: begin
        if (b == 0)                                 begin el = '1; eh = a; end
        else if (a == 32'h8000_0000 && b == '1)     begin el = 32'h8000_0000; eh = '0; end
        else begin el = 32'(sa / sb); eh = 32'(sa % sb); end
      end
      default: begin
        if (b == 0) begin el = '1; eh = a; end
        else        begin el = a / b; eh = a % b; end
      end
    endcase
  endfunction

  // Issue one operation from a sample point and follow it to completion.
  // Leaves the bench in the done cycle so a back-to-back start is possible.
  task automatic run_op(input logic [1:0] o, input logic [W-1:0] a, b, input string tag);
    logic [W-1:0] eh, el;
    int bad;
    start = 1'b1; op = o; opA = a; opB = b;
    tick();
    start = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    if (!DIV_EN && o[1]) begin
      check({tag, "_rej_busy"}, busy, 0);
      check({tag, "_rej_hi"}, hi, exp_hi);
      check({tag, "_rej_lo"}, lo, exp_lo);
      return;
    end
    model(o, a, b, eh, el);
    bad = 0;
    for (int k = 0; k <= W; k++) begin
      if (busy !== 1'b1 || done !== 1'b0 || hi !== exp_hi || lo !== exp_lo) bad++;
      tick();
    end
    check({tag, "_busy_window"}, bad, 0);
    check({tag, "_done"}, {done, busy}, 2'b10);
    check({tag, "_hi"}, hi, eh);
    check({tag, "_lo"}, lo, el);
    exp_hi = eh;
    exp_lo = el;
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      2:       return 32'h8000_0000;
      3:       return W'($urandom_range(0, 20)) - 10;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int bad;
    logic [1:0] ro;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; hi_we = 1'b0; lo_we = 1'b0;
    op = '0; opA = '0; opB = '0; wdata = '0;
    tick(); tick();
    rst_n = 1'b1;
    check("reset_outs", {busy, done, hi, lo}, '0);
    exp_hi = '0; exp_lo = '0;

    // Directed arithmetic cases
    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu_max");
    check("multu_max_hi_const", hi, 32'hFFFF_FFFE);
    run_op(2'b00, -32'sd3, 32'd5, "mult_neg");         // back-to-back, done cycle
    check("mult_neg_lo_const", lo, 32'hFFFF_FFF1);
    run_op(2'b00, 32'h8000_0000, 32'h8000_0000, "mult_min");
    run_op(2'b10, -32'sd7, 32'd2, "div_neg");
    run_op(2'b11, 32'd7, 32'd0, "divu_zero");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf");
    run_op(2'b10, -32'sd9, 32'd0, "div_zero_s");
    run_op(2'b10, 32'd8, 32'd2, "div_8_2");
    tick();
    check("done_single", done, 0);

    // MT writes while idle
    lo_we = 1'b1; wdata = 32'hABCD;
    tick();
    lo_we = 1'b0;
    exp_lo = 32'hABCD;
    check("mtlo", lo, 32'hABCD);

    // MT write in the same cycle as start: taken, then overwritten at FINISH
    hi_we = 1'b1; wdata = 32'h77; exp_hi = 32'h77;
    run_op(2'b01, 32'd6, 32'd7, "mt_start");
    check("multu_6x7_lo", lo, 32'd42);

    // Ignored start/MTHI while busy, then flush in CALC
    hi_we = 1'b1; wdata = 32'h11; tick();
    hi_we = 1'b0; lo_we = 1'b1; wdata = 32'h22; tick();
    lo_we = 1'b0;
    start = 1'b1; op = 2'b01; opA = 32'd3; opB = 32'd4;
    tick();                                     // accept edge, cycle 1 follows
    start = 1'b0;
    repeat (4) tick();                          // now in cycle 5
    start = 1'b1; hi_we = 1'b1; wdata = 32'h55; opA = 32'd9;
    tick();
    start = 1'b0; hi_we = 1'b0;
    check("busy_ignore_hi", hi, 32'h11);
    check("busy_still", busy, 1);
    repeat (4) tick();                          // now in cycle 10
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_calc", {busy, done, hi, lo}, {2'b00, 32'h11, 32'h22});
    bad = 0;
    for (int k = 0; k < W + 4; k++) begin
      if (done !== 1'b0 || busy !== 1'b0 || hi !== 32'h11 || lo !== 32'h22) bad++;
      tick();
    end
    check("flush_quiet", bad, 0);
    exp_hi = 32'h11; exp_lo = 32'h22;

    // Flush in the FINISH cycle beats the write
    start = 1'b1; op = 2'b01; opA = 32'd5; opB = 32'd5;
    tick();
    start = 1'b0;
    repeat (W) tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    check("flush_finish", {busy, done, hi, lo}, {2'b00, 32'h11, 32'h22});

    // flush with start in IDLE: start ignored
    flush = 1'b1; start = 1'b1; op = 2'b01;
    tick();
    flush = 1'b0; start = 1'b0;
    check("flush_start_idle", busy, 0);

    // Randomized operations against the model
    for (int n = 0; n < 40; n++) begin
      ro = 2'($urandom_range(0, 3));
      run_op(ro, pick(), pick(), $sformatf("rnd%0d_op%0d", n, ro));
      if ($urandom_range(0, 1) == 1) tick();
    end

    // Reset in the middle of an operation
    run_op(2'b01, 32'd3, 32'd5, "pre_reset");
    start = 1'b1; op = DIV_EN ? 2'b11 : 2'b01; opA = 32'd100; opB = 32'd7;
    tick();
    start = 1'b0;
    repeat (19) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("reset_midop", {busy, done, hi, lo}, '0);
    tick();
    check("reset_stays_idle", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
